// File: rtl/prog_mem_loader_if.sv
// Byte-stream input and Avalon-MM RAM master bundle for prog_mem_loader.
// The master modport is the loader's side; slave is the stream source plus RAM.
interface prog_mem_loader_if #(
  parameter int ADDR_W = 16
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write;
  logic [3:0]        m_byteenable;
  logic [31:0]       m_writedata;
  logic [31:0]       m_readdata;

  modport master (
    input  s_valid, s_data, m_readdata,
    output s_ready, m_address, m_chipselect, m_write, m_byteenable, m_writedata
  );

  modport slave (
    output s_valid, s_data, m_readdata,
    input  s_ready, m_address, m_chipselect, m_write, m_byteenable, m_writedata
  );
endinterface

// File: rtl/prog_mem_loader.sv
// Boot loader: packs a framed byte stream into 32-bit RAM writes, checks the
// frame checksum and optionally reads the written range back to verify it.
module prog_mem_loader #(
  parameter int         ADDR_W = 16,
  parameter logic [7:0] SYNC   = 8'hA5,
  parameter bit         VERIFY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  prog_mem_loader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WR, S_CSUM, S_VERIFY, S_ERR, S_FIN
  } state_t;

  state_t            state;
  logic [1:0]        hdr_cnt;
  logic [15:0]       addr;
  logic [15:0]       len;
  logic [15:0]       byte_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] last_idx;
  logic [31:0]       wbuf;
  logic [7:0]        sum_all;
  logic [7:0]        sum_pay;
  logic [7:0]        rd_sum;
  logic              wr_last;
  logic              pend;
  logic              pend_last;
  logic [3:0]        pend_mask;

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    logic [3:0] m;
    case (lane)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] masked_sum(input logic [31:0] d, input logic [3:0] m);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) s = s + d[8*i +: 8];
    end
    return s;
  endfunction

  logic              accept;
  logic [15:0]       len_full;
  logic [15:0]       words_full;
  logic [17:0]       end_addr;
  logic              range_bad;
  logic [ADDR_W-1:0] base;
  logic [31:0]       word_next;
  logic              last_byte;
  logic [3:0]        final_mask;
  logic [7:0]        rd_sum_next;
  logic              at_last_rd;

  assign accept     = bus.s_valid & bus.s_ready;
  assign len_full   = {bus.s_data, len[7:0]};
  assign words_full = 16'((17'(len_full) + 17'd3) >> 2);
  // Range check is done wider than the address so that a frame running past the top is caught, not wrapped.
  assign end_addr   = {2'b00, addr} + {2'b00, words_full};
  assign range_bad  = (len_full == 16'd0) || (end_addr > (18'd1 << ADDR_W));
  assign base       = addr[ADDR_W-1:0];
  assign word_next  = wbuf | ({24'd0, bus.s_data} << {byte_cnt[1:0], 3'b000});
  assign last_byte  = (byte_cnt == len - 16'd1);
  assign final_mask = lane_mask(len[1:0] - 2'd1);
  assign rd_sum_next = rd_sum + masked_sum(bus.m_readdata, pend_mask);
  assign at_last_rd = (word_idx == last_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      bus.s_ready      <= 1'b1;
      bus.m_address    <= '0;
      bus.m_chipselect <= 1'b0;
      bus.m_write      <= 1'b0;
      bus.m_byteenable <= 4'd0;
      bus.m_writedata  <= 32'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_code         <= 2'd0;
      hdr_cnt          <= 2'd0;
      addr             <= 16'd0;
      len              <= 16'd0;
      byte_cnt         <= 16'd0;
      word_idx         <= '0;
      last_idx         <= '0;
      wbuf             <= 32'd0;
      sum_all          <= 8'd0;
      sum_pay          <= 8'd0;
      rd_sum           <= 8'd0;
      wr_last          <= 1'b0;
      pend             <= 1'b0;
      pend_last        <= 1'b0;
      pend_mask        <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && bus.s_data == SYNC) begin
            state    <= S_HDR;
            busy     <= 1'b1;
            err_code <= 2'd0;
            hdr_cnt  <= 2'd0;
            sum_all  <= 8'd0;
            sum_pay  <= 8'd0;
            byte_cnt <= 16'd0;
            word_idx <= '0;
            wbuf     <= 32'd0;
          end
        end

        S_HDR: begin
          if (accept) begin
            sum_all <= sum_all + bus.s_data;
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              2'd0: addr[7:0]  <= bus.s_data;
              2'd1: addr[15:8] <= bus.s_data;
              2'd2: len[7:0]   <= bus.s_data;
              default: begin
                len[15:8] <= bus.s_data;
                last_idx  <= ADDR_W'(words_full - 16'd1);
                if (range_bad) begin
                  err_code    <= 2'd1;
                  state       <= S_ERR;
                  bus.s_ready <= 1'b0;
                end else begin
                  state <= S_DATA;
                end
              end
            endcase
          end
        end

        S_DATA: begin
          if (accept) begin
            sum_all  <= sum_all + bus.s_data;
            sum_pay  <= sum_pay + bus.s_data;
            byte_cnt <= byte_cnt + 16'd1;
            if (byte_cnt[1:0] == 2'd3 || last_byte) begin
              state            <= S_WR;
              bus.s_ready      <= 1'b0;
              bus.m_chipselect <= 1'b1;
              bus.m_write      <= 1'b1;
              bus.m_address    <= base + word_idx;
              bus.m_byteenable <= lane_mask(byte_cnt[1:0]);
              bus.m_writedata  <= word_next;
              wbuf             <= 32'd0;
              word_idx         <= word_idx + ADDR_W'(1);
              wr_last          <= last_byte;
            end else begin
              wbuf <= word_next;
            end
          end
        end

        S_WR: begin
          bus.m_chipselect <= 1'b0;
          bus.m_write      <= 1'b0;
          bus.m_byteenable <= 4'd0;
          bus.m_writedata  <= 32'd0;
          bus.s_ready      <= 1'b1;
          state            <= wr_last ? S_CSUM : S_DATA;
        end

        S_CSUM: begin
          if (accept) begin
            bus.s_ready <= 1'b0;
            if (bus.s_data != sum_all) begin
              err_code <= 2'd2;
              state    <= S_ERR;
            end else if (VERIFY) begin
              state            <= S_VERIFY;
              bus.m_chipselect <= 1'b1;
              bus.m_write      <= 1'b0;
              bus.m_address    <= base;
              word_idx         <= '0;
              rd_sum           <= 8'd0;
              pend             <= 1'b0;
            end else begin
              state <= S_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        // Read data trails its address by one clock, so pend/pend_mask describe what is on m_readdata now.
        S_VERIFY: begin
          if (pend) rd_sum <= rd_sum_next;
          if (bus.m_chipselect) begin
            pend      <= 1'b1;
            pend_last <= at_last_rd;
            pend_mask <= at_last_rd ? final_mask : 4'b1111;
            if (at_last_rd) begin
              bus.m_chipselect <= 1'b0;
            end else begin
              word_idx      <= word_idx + ADDR_W'(1);
              bus.m_address <= bus.m_address + ADDR_W'(1);
            end
          end else begin
            pend <= 1'b0;
          end
          if (pend && pend_last) begin
            if (rd_sum_next != sum_pay) err_code <= 2'd3;
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        S_ERR: begin
          state <= S_FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        S_FIN: begin
          state       <= S_IDLE;
          bus.s_ready <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: directed frames plus random frames, checked on
// every bus cycle against a frame-level model of expected writes, reads and error code.
module tb_prog_mem_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic [31:0] readdata = 32'd0;
  bit          sel = 1'b0;
  bit          gaps = 1'b0;
  bit          fault_on = 1'b0;
  logic [15:0] fault_addr = 16'd0;

  logic        busy0, done0, busy1, done1;
  logic [1:0]  err0, err1;

  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int          rd_cnt = 0;
  logic [1:0]  exp_err = 2'd0;
  logic [7:0]  last_csum;
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  wr_t         wr_log[$];
  logic [7:0]  pay[$];
  logic [31:0] mem [0:65535];

  prog_mem_loader_if #(.ADDR_W(16)) bus0 ();
  prog_mem_loader_if #(.ADDR_W(16)) bus1 ();

  assign bus0.s_valid    = s_valid & ~sel;
  assign bus1.s_valid    = s_valid & sel;
  assign bus0.s_data     = s_data;
  assign bus1.s_data     = s_data;
  assign bus0.m_readdata = readdata;
  assign bus1.m_readdata = readdata;

  prog_mem_loader #(.ADDR_W(16), .SYNC(8'hA5), .VERIFY(1'b1)) dut_v (
    .clk(clk), .reset(reset), .bus(bus0.master),
    .busy(busy0), .done(done0), .err_code(err0)
  );

  prog_mem_loader #(.ADDR_W(16), .SYNC(8'hA5), .VERIFY(1'b0)) dut_nv (
    .clk(clk), .reset(reset), .bus(bus1.master),
    .busy(busy1), .done(done1), .err_code(err1)
  );

  logic        s_ready_sel, cs_sel, wr_sel, busy_sel, done_sel;
  logic [15:0] addr_sel;
  logic [3:0]  be_sel;
  logic [31:0] wd_sel;
  logic [1:0]  err_sel;

  assign s_ready_sel = sel ? bus1.s_ready      : bus0.s_ready;
  assign cs_sel      = sel ? bus1.m_chipselect : bus0.m_chipselect;
  assign wr_sel      = sel ? bus1.m_write      : bus0.m_write;
  assign addr_sel    = sel ? bus1.m_address    : bus0.m_address;
  assign be_sel      = sel ? bus1.m_byteenable : bus0.m_byteenable;
  assign wd_sel      = sel ? bus1.m_writedata  : bus0.m_writedata;
  assign busy_sel    = sel ? busy1 : busy0;
  assign done_sel    = sel ? done1 : done0;
  assign err_sel     = sel ? err1  : err0;

  always #5 clk = ~clk;

  // RAM model: byte-enabled writes, registered reads with an optional bit-0 fault.
  always @(posedge clk) begin
    if (cs_sel && wr_sel) begin
      for (int j = 0; j < 4; j++)
        if (be_sel[j]) mem[addr_sel][8*j +: 8] <= wd_sel[8*j +: 8];
    end
    if (cs_sel && !wr_sel)
      readdata <= mem[addr_sel] ^ ((fault_on && addr_sel == fault_addr) ? 32'd1 : 32'd0);
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t act, e;
    if (!reset) begin
      if (cs_sel && wr_sel) begin
        act = {addr_sel, be_sel, wd_sel};
        wr_log.push_back(act);
        check_output("write_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check_output("write_addr_be_data", 64'(act), 64'(e));
        end
        check_output("ready_low_in_write", 64'(s_ready_sel), 64'd0);
      end
      if (cs_sel && !wr_sel) begin
        rd_cnt++;
        check_output("read_expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) check_output("read_addr", 64'(addr_sel), 64'(exp_rd.pop_front()));
        check_output("ready_low_in_read", 64'(s_ready_sel), 64'd0);
      end
      if (done_sel) begin
        done_seen++;
        check_output("done_err_code", 64'(err_sel), 64'(exp_err));
        check_output("done_busy_low", 64'(busy_sel), 64'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready_sel && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("byte_accepted", 64'(s_ready_sel), 64'd1);
    @(negedge clk);
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  // Frame-level model: which words must be written, which addresses read, what error results.
  task automatic apply_stimulus(input logic [15:0] a, input int len, input int delta, input bit noise);
    int words, start, n;
    logic [7:0]  csum;
    logic [15:0] l16;
    wr_t e;
    l16   = 16'(len);
    words = (len + 3) / 4;
    csum  = a[7:0] + a[15:8] + l16[7:0] + l16[15:8];
    foreach (pay[k]) csum = csum + pay[k];
    csum = csum + 8'(delta);
    last_csum = csum;
    exp_wr.delete();
    exp_rd.delete();
    wr_log.delete();
    rd_cnt = 0;
    if (len == 0 || int'(a) + words > 65536) begin
      exp_err = 2'd1;
    end else begin
      for (int w = 0; w < words; w++) begin
        e.addr = a + 16'(w);
        e.be   = 4'd0;
        e.data = 32'd0;
        for (int j = 0; j < 4; j++) begin
          if (4*w + j < len) begin
            e.data[8*j +: 8] = pay[4*w + j];
            e.be[j] = 1'b1;
          end
        end
        exp_wr.push_back(e);
      end
      if (8'(delta) != 8'd0) begin
        exp_err = 2'd2;
      end else if (!sel) begin
        for (int w = 0; w < words; w++) exp_rd.push_back(a + 16'(w));
        exp_err = (fault_on && int'(fault_addr) >= int'(a) && int'(fault_addr) < int'(a) + words) ? 2'd3 : 2'd0;
      end else begin
        exp_err = 2'd0;
      end
    end
    start = done_seen;
    if (noise) begin
      send_byte(8'h00);
      send_byte(8'hFF);
      check_output("noise_dropped_idle", 64'(busy_sel), 64'd0);
    end
    send_byte(8'hA5);
    check_output("busy_in_frame", 64'(busy_sel), 64'd1);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(l16[7:0]);
    send_byte(l16[15:8]);
    if (exp_err != 2'd1) begin
      foreach (pay[k]) send_byte(pay[k]);
      send_byte(csum);
    end
    s_valid = 1'b0;
    n = 0;
    while (done_seen == start && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_output("done_once", 64'(done_seen - start), 64'd1);
    check_output("writes_all_seen", 64'(exp_wr.size()), 64'd0);
    check_output("reads_all_seen", 64'(exp_rd.size()), 64'd0);
  endtask

  task automatic load_seq(input logic [7:0] first, input logic [7:0] step, input int len);
    pay.delete();
    for (int k = 0; k < len; k++) pay.push_back(first + 8'(k) * step);
  endtask

  task automatic check_reset_state();
    check_output("rst_s_ready", 64'(s_ready_sel), 64'd1);
    check_output("rst_busy", 64'(busy_sel), 64'd0);
    check_output("rst_done", 64'(done_sel), 64'd0);
    check_output("rst_err", 64'(err_sel), 64'd0);
    check_output("rst_cs_we", 64'({cs_sel, wr_sel}), 64'd0);
  endtask

  initial begin
    int start;
    logic [15:0] a;
    int len, delta;
    for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state();

    load_seq(8'h01, 8'h01, 8);
    apply_stimulus(16'h0010, 8, 0, 1'b0);
    check_output("t1_csum_byte", 64'(last_csum), 64'h3C);
    check_output("t1_wr0", 64'(wr_log.size() > 0 ? wr_log[0] : '0), 64'({16'h0010, 4'hF, 32'h04030201}));
    check_output("t1_wr1", 64'(wr_log.size() > 1 ? wr_log[1] : '0), 64'({16'h0011, 4'hF, 32'h08070605}));
    check_output("t1_reads", 64'(rd_cnt), 64'd2);
    check_output("t1_err", 64'(err_sel), 64'd0);

    load_seq(8'h11, 8'h11, 5);
    apply_stimulus(16'h0020, 5, 0, 1'b0);
    check_output("t2_wr0", 64'(wr_log.size() > 0 ? wr_log[0] : '0), 64'({16'h0020, 4'hF, 32'h44332211}));
    check_output("t2_wr1", 64'(wr_log.size() > 1 ? wr_log[1] : '0), 64'({16'h0021, 4'h1, 32'h00000055}));

    load_seq(8'h01, 8'h01, 8);
    apply_stimulus(16'h0010, 8, 1, 1'b0);
    check_output("t3_err_csum", 64'(err_sel), 64'd2);
    check_output("t3_writes", 64'(wr_log.size()), 64'd2);
    check_output("t3_no_reads", 64'(rd_cnt), 64'd0);

    pay.delete();
    apply_stimulus(16'hFFFF, 5, 0, 1'b0);
    check_output("t4_err_range", 64'(err_sel), 64'd1);
    check_output("t4_no_writes", 64'(wr_log.size()), 64'd0);
    apply_stimulus(16'h0040, 0, 0, 1'b0);
    check_output("t4_err_zero_len", 64'(err_sel), 64'd1);
    load_seq(8'h90, 8'h03, 8);
    apply_stimulus(16'hFFFE, 8, 0, 1'b0);
    check_output("t4_top_fit_err", 64'(err_sel), 64'd0);

    fault_on = 1'b1;
    fault_addr = 16'h0011;
    load_seq(8'h01, 8'h01, 8);
    apply_stimulus(16'h0010, 8, 0, 1'b0);
    check_output("t5_err_verify", 64'(err_sel), 64'd3);
    sel = 1'b1;
    apply_stimulus(16'h0010, 8, 0, 1'b0);
    check_output("t5_noverify_err", 64'(err_sel), 64'd0);
    check_output("t5_noverify_reads", 64'(rd_cnt), 64'd0);
    sel = 1'b0;
    fault_on = 1'b0;

    load_seq(8'hA5, 8'h07, 11);
    apply_stimulus(16'h0100, 11, 0, 1'b1);

    load_seq(8'h31, 8'h01, 8);
    exp_wr.delete();
    exp_rd.delete();
    wr_log.delete();
    start = done_seen;
    send_byte(8'hA5);
    send_byte(8'h30);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h00);
    for (int k = 0; k < 3; k++) send_byte(pay[k]);
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state();
    repeat (10) @(negedge clk);
    check_output("abort_no_write", 64'(wr_log.size()), 64'd0);
    check_output("abort_no_done", 64'(done_seen - start), 64'd0);
    load_seq(8'h01, 8'h01, 8);
    apply_stimulus(16'h0010, 8, 0, 1'b0);
    check_output("after_abort_err", 64'(err_sel), 64'd0);

    for (int f = 0; f < 40; f++) begin
      sel   = ($urandom_range(0, 3) == 0);
      gaps  = $urandom_range(0, 1) == 1;
      len   = ($urandom_range(0, 12) == 0) ? 0 : $urandom_range(1, 14);
      a     = ($urandom_range(0, 7) == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 4)))
                                          : 16'($urandom_range(0, 200));
      delta = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 255) : 0;
      fault_on   = ($urandom_range(0, 4) == 0);
      fault_addr = a + 16'($urandom_range(0, 3));
      pay.delete();
      for (int k = 0; k < len; k++) pay.push_back(8'($urandom));
      apply_stimulus(a, len, delta, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
